multiplication_unsigned_32: RTL and testbench



---
 rtl/multiplication_unsigned_32_pkg.sv | 8 +
 rtl/multiplication_unsigned_32_rise_detect.sv | 14 +
 rtl/multiplication_unsigned_32.sv | 62 ++++++
 tb/tb_multiplication_unsigned_32.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/multiplication_unsigned_32_pkg.sv
// multiplication_unsigned_32_pkg: ALU FSM states shared with the divider, plus the iteration counter width helper.
package multiplication_unsigned_32_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int WIDTH_DEFAULT = 32;
  function automatic int cnt_width(int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/multiplication_unsigned_32_rise_detect.sv
// rise_detect: registers d every clock and flags its rising edge.
// Ports: clock, reset_n (async active-low), d (level input), pulse (d & ~d_q, combinational).
module rise_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic pulse
);
  logic d_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) d_q <= 1'b0;
    else d_q <= d;
  assign pulse = d & ~d_q;
endmodule

// File: rtl/multiplication_unsigned_32.sv
// multiplication_unsigned_32: shift-add multiply-accumulate, result = operand1*operand2 + addend, one bit per clock.
// Ports: clock, reset_n (async active-low), start (rising edge requests), operand1/operand2/addend (WIDTH),
//        result (2*WIDTH, held until next completion), finish (result valid), busy (iterating).
module multiplication_unsigned_32
  import multiplication_unsigned_32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  input  logic [WIDTH-1:0]   addend,
  output logic [2*WIDTH-1:0] result,
  output logic               finish,
  output logic               busy
);
  localparam int CW = cnt_width(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [WIDTH:0] sum;
  logic req, accept, last;
  rise_detect u_rise (.clock(clock), .reset_n(reset_n), .d(start), .pulse(req));
  // hi starts at addend, so the accumulated product already includes it; sum carries at most WIDTH+1 bits.
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    accept = req & (state != BUSY);
    last = (state == BUSY) && (cnt == CW'(WIDTH - 1));
    state_n = accept ? BUSY : last ? DONE : state;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mcand <= '0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      result <= '0;
      finish <= 1'b0;
      busy <= 1'b0;
    end else if (accept) begin
      mcand <= operand1;
      hi <= addend;
      lo <= operand2;
      cnt <= '0;
      finish <= 1'b0;
      busy <= 1'b1;
    end else if (state == BUSY) begin
      hi <= sum[WIDTH:1];
      lo <= {sum[0], lo[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      if (last) begin
        result <= {sum, lo[WIDTH-1:1]};
        finish <= 1'b1;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_multiplication_unsigned_32.sv
// tb_multiplication_unsigned_32: scoreboard bench with random and directed multiply-accumulate operations.
module tb_multiplication_unsigned_32;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [31:0] op1 = '0, op2 = '0, add = '0;
  logic [63:0] result;
  logic finish, busy, fin_prev = 1'b0;
  int cyc = 0, errors = 0, checks = 0;
  logic [63:0] eq[$];
  int aq[$];

  multiplication_unsigned_32 dut (
    .clock(clk), .reset_n(reset_n), .start(start), .operand1(op1), .operand2(op2),
    .addend(add), .result(result), .finish(finish), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    return 64'(a) * 64'(b) + 64'(c);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every rising finish must match the oldest outstanding operation, 32 clocks after its accept.
  always @(negedge clk) begin
    if (finish && !fin_prev) begin
      if (eq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish: got result %h expected no completion", result);
      end else begin
        chk("result", result, eq.pop_front());
        chk("latency", 64'(cyc - aq.pop_front()), 64'd32);
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
    fin_prev <= finish;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int hold);
    @(negedge clk);
    op1 = a; op2 = b; add = c; start = 1'b1;
    @(posedge clk);
    #1;
    eq.push_back(model(a, b, c));
    aq.push_back(cyc);
    op1 = $urandom; op2 = $urandom; add = $urandom;
    if (hold == 0) start = 1'b0;
    else begin
      repeat (hold - 1) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (eq.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (eq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending operations expected 0", eq.size());
      eq.delete();
      aq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_finish", 64'(finish), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    #13 reset_n = 1'b1;
    issue(32'h1000_0000, 32'h10, 32'h0, 5);
    wait_done();
    chk("long_start_single_op", result, 64'h0000_0001_0000_0000);
    repeat (10) @(negedge clk);
    chk("no_second_op", 64'(finish), 64'd1);
    issue(32'd1111, 32'd2, 32'd0, 0);
    wait_done();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done();
    issue(32'd100, 32'd7, 32'd3, 1);
    wait_done();
    issue(32'd200, 32'd0, 32'd7, 1);
    wait_done();
    chk("zero_mult", result, 64'd7);
    @(negedge clk);
    op1 = 32'd3; op2 = 32'd4; add = 32'd0; start = 1'b1;
    @(posedge clk);
    #1;
    eq.push_back(model(32'd3, 32'd4, 32'd0));
    aq.push_back(cyc);
    chk("restart_finish_drops", 64'(finish), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_result_held", result, 64'd7);
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    chk("result_held_midway", result, 64'd7);
    wait_done();
    chk("restart_result", result, 64'd12);
    issue(32'd12345, 32'd678, 32'd9, 1);
    repeat (5) @(negedge clk);
    op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678; add = 32'h55; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    chk("busy_ignored", result, model(32'd12345, 32'd678, 32'd9));
    repeat (8) @(negedge clk);
    chk("no_queued_op", 64'(busy), 64'd0);
    for (int i = 0; i < 10; i++) begin
      issue($urandom, $urandom, $urandom, $urandom_range(0, 4));
      wait_done();
    end
    issue(32'hFFFF_0000, 32'h0000_FFFF, 32'h1, 1);
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_result", result, 64'd0);
    chk("async_reset_finish", 64'(finish), 64'd0);
    chk("async_reset_busy", 64'(busy), 64'd0);
    eq.delete();
    aq.delete();
    @(negedge clk) reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("reset_no_finish", 64'(finish), 64'd0);
    issue(32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h7777_7777, 2);
    wait_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
